// File: rtl/steer_pkg.sv
// Shared types and default tuning for the steering-enable FSM.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  localparam int unsigned SETTLE_W = 26;
  localparam int unsigned DBNC_W   = 16;

  localparam int unsigned DEF_LD_W     = 12;
  localparam int unsigned DEF_MIN_WT   = 'h200;
  localparam int unsigned DEF_HYST     = 'h020;
  localparam int unsigned DEF_EN_SHFT  = 2;
  localparam int unsigned DEF_OFF_SHFT = 4;

  localparam logic [SETTLE_W-1:0] DEF_SETTLE_CNT  = 26'd65_000_000;
  localparam logic [DBNC_W-1:0]   DEF_DBNC_CNT    = 16'd5000;
  // Short timings so simulations reach STEER_EN in a few dozen cycles.
  localparam logic [SETTLE_W-1:0] FAST_SETTLE_CNT = 26'd16;
  localparam logic [DBNC_W-1:0]   FAST_DBNC_CNT   = 16'd4;

endpackage

// File: rtl/steer_en_gen2_sat_cnt.sv
// Saturating up-counter; full when the count reaches MAX-1 and holds there.
module sat_cnt #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = 8'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [W-1:0] cnt;

  assign full = (cnt == MAX - W'(1));

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !full) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/steer_en_gen2.sv
// Rider-detect / steering-enable FSM: settles on balanced load before enabling
// steering, debounces rider loss, and reports state plus registered |lft-rght|.
module steer_en_gen2
  import steer_pkg::*;
#(
  parameter int unsigned          LD_W       = DEF_LD_W,
  parameter logic [LD_W-1:0]      MIN_WT     = LD_W'(DEF_MIN_WT),
  parameter logic [LD_W-1:0]      HYST       = LD_W'(DEF_HYST),
  parameter int unsigned          EN_SHFT    = DEF_EN_SHFT,
  parameter int unsigned          OFF_SHFT   = DEF_OFF_SHFT,
  parameter logic [SETTLE_W-1:0]  SETTLE_CNT = DEF_SETTLE_CNT,
  parameter logic [DBNC_W-1:0]    DBNC_CNT   = DEF_DBNC_CNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic [LD_W-1:0] ld_cell_diff,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      sm_status
);

  localparam logic [LD_W:0] LIM_ON  = {1'b0, MIN_WT};
  localparam logic [LD_W:0] LIM_OFF = {1'b0, MIN_WT - HYST};

  state_t          state;
  logic [LD_W-1:0] lft_q, rght_q, abs_d;
  logic [LD_W:0]   sum;
  logic            wt_on, wt_low, unbal, step_off, lost;
  logic            tmr_full, tmr_clr, dbnc_full, to_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q        <= '0;
      rght_q       <= '0;
      ld_cell_diff <= '0;
    end else begin
      lft_q        <= lft_ld;
      rght_q       <= rght_ld;
      ld_cell_diff <= abs_d;
    end
  end

  // Subtract the smaller from the larger so |0 - max| never wraps.
  assign sum      = {1'b0, lft_q} + {1'b0, rght_q};
  assign abs_d    = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  assign wt_on    = sum > LIM_ON;
  assign wt_low   = sum < LIM_OFF;
  assign unbal    = {1'b0, abs_d} > (sum >> EN_SHFT);
  assign step_off = {1'b0, abs_d} > (sum - (sum >> OFF_SHFT));
  assign lost     = wt_low && dbnc_full;

  assign tmr_clr = ((state == IDLE) && wt_on) ||
                   ((state == WAIT) && unbal) ||
                   ((state == STEER_EN) && !lost && step_off);

  sat_cnt #(.W(SETTLE_W), .MAX(SETTLE_CNT)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .inc  (state == WAIT),
    .full (tmr_full)
  );

  sat_cnt #(.W(DBNC_W), .MAX(DBNC_CNT)) u_dbnc (
    .clk  (clk),
    .rst  (rst),
    .clr  (!wt_low || (state == IDLE)),
    .inc  (wt_low),
    .full (dbnc_full)
  );

  // Outputs trail the state register by one cycle; to_idle carries the
  // exit event so rider_off lines up with en_steer dropping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      to_idle   <= 1'b0;
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      to_idle   <= 1'b0;
      en_steer  <= (state == STEER_EN);
      rider_off <= to_idle;
      case (state)
        IDLE:     if (wt_on) state <= WAIT;
        WAIT: begin
          if (lost) begin
            state   <= IDLE;
            to_idle <= 1'b1;
          end else if (!unbal && tmr_full) begin
            state <= STEER_EN;
          end
        end
        STEER_EN: begin
          if (lost) begin
            state   <= IDLE;
            to_idle <= 1'b1;
          end else if (step_off) begin
            state <= WAIT;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

  assign sm_status = state;

endmodule

// File: tb/tb_steer_en_gen2.sv
// Randomised and directed bench for steer_en_gen2 against a run-length model.
module tb_steer_en_gen2;
  import steer_pkg::*;

  localparam int ST   = int'(FAST_SETTLE_CNT);
  localparam int DB   = int'(FAST_DBNC_CNT);
  localparam int MINW = 'h200;
  localparam int HYS  = 'h020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lft_ld = '0, rght_ld = '0;
  logic [11:0] ld_cell_diff;
  logic        en_steer, rider_off;
  logic [1:0]  sm_status;

  int errors = 0;
  int checks = 0;

  // reference model: state as a small int, run lengths for settle/debounce
  logic [1:0]  m_st = 2'd0;
  logic        m_en = 1'b0, m_roff = 1'b0, m_pend = 1'b0;
  logic [11:0] m_diff = '0;
  int          q_l = 0, q_r = 0, m_low = 0, m_bal = 0;

  wire [15:0] obs = {sm_status, en_steer, rider_off, ld_cell_diff};

  always #5 clk = ~clk;

  steer_en_gen2 #(
    .LD_W(12), .MIN_WT(12'h200), .HYST(12'h020), .EN_SHFT(2), .OFF_SHFT(4),
    .SETTLE_CNT(FAST_SETTLE_CNT), .DBNC_CNT(FAST_DBNC_CNT)
  ) dut (
    .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .ld_cell_diff(ld_cell_diff), .en_steer(en_steer),
    .rider_off(rider_off), .sm_status(sm_status)
  );

  function automatic logic [15:0] mexp();
    return {m_st, m_en, m_roff, m_diff};
  endfunction

  // Advance one clock and update the model from the values registered last edge.
  task automatic tick();
    int s, a;
    bit wt_on, wt_low, unbal, stp, lost;
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_en = 0; m_roff = 0; m_pend = 0; m_diff = 0;
      q_l = 0; q_r = 0; m_low = 0; m_bal = 0;
    end else begin
      s      = q_l + q_r;
      a      = (q_l > q_r) ? q_l - q_r : q_r - q_l;
      wt_on  = s > MINW;
      wt_low = s < MINW - HYS;
      unbal  = a > s / 4;
      stp    = a > s - s / 16;
      m_diff = 12'(a);
      m_en   = (m_st == 2'd2);
      m_roff = m_pend;
      m_pend = 0;
      m_low  = (m_st != 0 && wt_low) ? m_low + 1 : 0;
      lost   = m_low >= DB;
      case (m_st)
        2'd0: if (wt_on) begin m_st = 1; m_bal = 0; end
        2'd1: if (lost) begin m_st = 0; m_pend = 1; end
              else if (unbal) m_bal = 0;
              else begin m_bal++; if (m_bal >= ST) m_st = 2; end
        default: if (lost) begin m_st = 0; m_pend = 1; end
                 else if (stp) begin m_st = 1; m_bal = 0; end
      endcase
      q_l = lft_ld;
      q_r = rght_ld;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; lft_ld = 12'h3AA; rght_ld = 12'h111;
    tick(); tick();
    checks++; if (obs !== 16'h0) begin errors++; $display("FAIL reset_outs got=%h exp=%h", obs, 16'h0); end
    checks++; if (obs !== mexp()) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, mexp()); end
    rst = 0; lft_ld = 0; rght_ld = 0;
    tick();
  endtask

  task automatic test_settle();
    int n = 0;
    lft_ld = 12'h150; rght_ld = 12'h150;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      checks++; if (obs !== mexp()) begin errors++; $display("FAIL settle_model t=%0d got=%h exp=%h", i, obs, mexp()); end
      if (i == 2) begin
        checks++; if (sm_status !== 2'd1) begin errors++; $display("FAIL settle_wait_entry got=%0d exp=1", sm_status); end
      end
      if (en_steer === 1'b1) n = i;
    end
    checks++; if (n != 19) begin errors++; $display("FAIL settle_latency got=%0d exp=19", n); end
    checks++; if (ld_cell_diff !== 12'h0) begin errors++; $display("FAIL settle_diff got=%h exp=0", ld_cell_diff); end
  endtask

  task automatic test_rebalance();
    int n = 0;
    rst = 1; tick(); rst = 0;
    lft_ld = 12'h150; rght_ld = 12'h150;
    repeat (4) tick();
    lft_ld = 12'h200; rght_ld = 12'h080;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (obs !== mexp() || en_steer !== 1'b0) begin errors++; $display("FAIL unbal_hold t=%0d got=%h exp=%h", i, obs, mexp()); end
    end
    lft_ld = 12'h150; rght_ld = 12'h150;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      checks++; if (obs !== mexp()) begin errors++; $display("FAIL rebal_model t=%0d got=%h exp=%h", i, obs, mexp()); end
      if (en_steer === 1'b1) n = i;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL rebal_latency got=%0d exp=18", n); end
  endtask

  task automatic test_step_off();
    int pulses = 0;
    lft_ld = 12'h1F0; rght_ld = 12'h008;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (obs !== mexp()) begin errors++; $display("FAIL stepoff_model t=%0d got=%h exp=%h", i, obs, mexp()); end
      if (i == 2) begin
        checks++; if (sm_status !== 2'd1 || en_steer !== 1'b1) begin errors++; $display("FAIL stepoff_wait got=%0d/%0d exp=1/1", sm_status, en_steer); end
      end
      if (i == 3) begin
        checks++; if (en_steer !== 1'b0) begin errors++; $display("FAIL stepoff_en_drop got=%0d exp=0", en_steer); end
      end
      if (rider_off === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL stepoff_rider_off got=%0d exp=0", pulses); end
  endtask

  task automatic reach_steer(input string tag);
    lft_ld = 12'h150; rght_ld = 12'h150;
    for (int i = 0; i < 40 && sm_status !== 2'd2; i++) tick();
    checks++; if (sm_status !== 2'd2) begin errors++; $display("FAIL %s_reach got=%0d exp=2", tag, sm_status); end
  endtask

  task automatic test_debounce();
    int pulses = 0, idle_at = 0, bad = 0;
    reach_steer("dbnc");
    lft_ld = 12'h0E8; rght_ld = 12'h0E8;
    repeat (3) tick();
    lft_ld = 12'h150; rght_ld = 12'h150;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sm_status !== 2'd2 || obs !== mexp()) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL dip_stays_steer got=%0d bad cycles exp=0", bad); end
    lft_ld = 12'h0E8; rght_ld = 12'h0E8;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (obs !== mexp()) begin errors++; $display("FAIL dbnc_model t=%0d got=%h exp=%h", i, obs, mexp()); end
      if (idle_at == 0 && sm_status === 2'd0) idle_at = i;
      if (rider_off === 1'b1) pulses++;
    end
    checks++; if (idle_at != 5) begin errors++; $display("FAIL dbnc_exit_time got=%0d exp=5", idle_at); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL dbnc_pulses got=%0d exp=1", pulses); end
    checks++; if (en_steer !== 1'b0) begin errors++; $display("FAIL dbnc_en got=%0d exp=0", en_steer); end
  endtask

  task automatic test_hysteresis();
    int bad = 0;
    lft_ld = 12'h0F8; rght_ld = 12'h0F8;
    for (int i = 0; i < 6; i++) begin tick(); if (sm_status !== 2'd0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL hyst_idle got=%0d bad cycles exp=0", bad); end
    reach_steer("hyst");
    lft_ld = 12'h0F8; rght_ld = 12'h0F8;
    bad = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (sm_status !== 2'd2 || en_steer !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL hyst_steer got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    reach_steer("rstmid");
    tick();
    rst = 1; tick(); rst = 0;
    checks++; if (obs !== 16'h0) begin errors++; $display("FAIL rstmid_outs got=%h exp=0000", obs); end
    lft_ld = 0; rght_ld = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (rider_off === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_rider_off got=%0d exp=0", pulses); end
    lft_ld = 12'hFFF; rght_ld = 12'h000;
    tick(); tick();
    checks++; if (ld_cell_diff !== 12'hFFF) begin errors++; $display("FAIL diff_max got=%h exp=fff", ld_cell_diff); end
    lft_ld = 12'h000; rght_ld = 12'hFFF;
    tick(); tick();
    checks++; if (obs !== mexp() || ld_cell_diff !== 12'hFFF) begin errors++; $display("FAIL diff_max_rev got=%h exp=%h", obs, mexp()); end
  endtask

  task automatic test_random();
    int w, len, bad = 0, steer_seen = 0;
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 29) == 0) begin rst = 1; tick(); rst = 0; end
      case ($urandom_range(0, 3))
        0: begin w = $urandom_range('h100, 'h7FF); lft_ld = 12'(w); rght_ld = 12'(w + $urandom_range(0, 'h40) - 'h20); end
        1: begin lft_ld = 12'($urandom_range(0, 'hE0)); rght_ld = 12'($urandom_range(0, 'hE0)); end
        2: begin lft_ld = 12'($urandom); rght_ld = 12'($urandom); end
        default: begin w = $urandom_range('hE0, 'h110); lft_ld = 12'(w); rght_ld = 12'(w + $urandom_range(0, 8)); end
      endcase
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        tick();
        checks++;
        if (obs !== mexp()) begin
          errors++; bad++;
          if (bad <= 10) $display("FAIL random seg=%0d got=%h exp=%h", seg, obs, mexp());
        end
        if (sm_status === 2'd2) steer_seen++;
      end
    end
    checks++; if (steer_seen == 0) begin errors++; $display("FAIL random_coverage got=0 steer cycles exp>0"); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_rebalance();
    test_step_off();
    test_debounce();
    test_hysteresis();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/steer_en_gen2.md
Name: steer_en_gen2

Overview:
- Parametrised successor to the rider-detect / steering-enable FSM.
- Takes left/right load-cell readings from the A2D interface and decides when a rider is on and balanced. Asserts en_steer to balance_cntrl after a programmable settle time.
- Pulses rider_off when the rider is lost.
- Adds to the prior generation: generic width, programmable thresholds, weight hysteresis, a step-off debounce, registered outputs and a status code.

Parameters:
- LD_W, 12, load-cell sample width (unsigned).
- MIN_WT, 12'h200, rider-on threshold on lft+rght.
- HYST, 12'h020, hysteresis; rider-off threshold is MIN_WT-HYST (HYST < MIN_WT).
- EN_SHFT, 2, balance-check shift; WAIT requires |diff| <= sum>>EN_SHFT (1/4).
- OFF_SHFT, 4, step-off shift; STEER_EN leaves when |diff| > sum - (sum>>OFF_SHFT) (15/16).
- SETTLE_CNT, 26'd65_000_000, balanced cycles required in WAIT (1.3 s at 50 MHz); >= 2.
- DBNC_CNT, 16'd5000, consecutive low-weight cycles before rider loss is accepted; >= 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- lft_ld  in  LD_W  left load cell.
- rght_ld  in  LD_W  right load cell.
- ld_cell_diff  out  LD_W  registered |lft_ld - rght_ld|.
- en_steer  out  1  steering enable to balance_cntrl.
- rider_off  out  1  one-cycle pulse on return to IDLE.
- sm_status  out  2  current state code (IDLE=0, WAIT=1, STEER_EN=2).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All flops reset only on a rising clk edge with rst=1.
- Reset values:
  - state=IDLE, both counters 0, input registers 0.
  - ld_cell_diff=0, en_steer=0, rider_off=0, sm_status=0.
- Stage 1: lft_ld/rght_ld are registered into lft_q/rght_q. All comparisons use the _q values.
- Arithmetic:
  - sum = lft_q + rght_q, LD_W+1 bits, no overflow.
  - diff computed in LD_W+1 bits signed; abs result fits LD_W. |0 - max| = max, no wrap.
  - Threshold terms are compared at LD_W+1 bits.
- Derived flags:
  - wt_on = sum > MIN_WT.
  - wt_low = sum < MIN_WT-HYST.
  - unbal = abs > (sum>>EN_SHFT).
  - step_off = abs > sum - (sum>>OFF_SHFT).
- ld_cell_diff = registered abs; 2-cycle latency from inputs.
- Settle timer:
  - Saturating; full when cnt == SETTLE_CNT-1.
  - Clears on IDLE->WAIT entry, STEER_EN->WAIT re-entry, and any WAIT cycle with unbal.
  - Increments in WAIT otherwise.
- Debounce counter:
  - Increments while wt_low in WAIT or STEER_EN.
  - Clears whenever wt_low=0 or in IDLE.
  - lost = wt_low && dbnc_cnt == DBNC_CNT-1.
- FSM, priority top to bottom within each state:
  - IDLE: wt_on -> WAIT (clear timer). Otherwise stay. A sum between the thresholds stays IDLE.
  - WAIT: lost -> IDLE. Else unbal -> WAIT (clear timer). Else tmr_full -> STEER_EN. Else stay.
  - STEER_EN: lost -> IDLE. Else step_off -> WAIT (clear timer). Else stay.
- Outputs:
  - en_steer = registered (state==STEER_EN): high the cycle after entry, low the cycle after exit.
  - rider_off = registered pulse, exactly 1 cycle, the cycle after any ->IDLE transition. Never asserted coming out of reset.
  - sm_status = state.
- Simultaneous events: lost beats unbal/step_off/tmr_full. A 1-cycle dip in weight never exits unless DBNC_CNT=1.
- rst mid-operation: next edge forces reset values; no rider_off pulse is generated.
- Unused state encoding 3 -> IDLE.

Decomposition:
- Package steer_pkg:
  - state typedef enum logic[1:0] {IDLE, WAIT, STEER_EN}.
  - Default threshold localparams.
  - FAST_SETTLE_CNT / FAST_DBNC_CNT for simulation.
- Sub-module sat_cnt (parameters W, MAX; inputs clr, inc; output full), instantiated twice: settle timer and debounce.

Test Plan:
1. Bench parameters: SETTLE_CNT=16, DBNC_CNT=4. Reset, then lft=rght=0x150 (sum 0x2A0) held -> WAIT 2 cycles after apply, en_steer=1 exactly 16 WAIT cycles later, ld_cell_diff=0.
2. In WAIT, lft=0x200, rght=0x080 (abs 0x180 > 0x280>>2=0xA0) for 5 cycles, then balanced -> timer restarts; en_steer arrives 16 cycles after rebalance, not earlier.
3. In STEER_EN, lft=0x1F0, rght=0x8: abs 0x1E8 <= 0x1F8-0x1F=0x1D9? No, 0x1E8 > 0x1D9 -> step_off; WAIT, en_steer drops next cycle, rider_off stays 0.
4. In STEER_EN, sum=0x1D0 (below 0x1E0) for 3 cycles then 0x2A0 -> stays STEER_EN. Sum 0x1D0 held for 4 cycles -> IDLE, one rider_off pulse, en_steer=0.
5. Hysteresis: from IDLE, sum=0x1F0 -> stays IDLE. After STEER_EN, sum=0x1F0 -> stays STEER_EN.
6. Assert rst for 1 cycle while in STEER_EN -> all outputs 0 next edge, rider_off never pulses. Also check lft=0xFFF, rght=0 gives ld_cell_diff=0xFFF with no overflow.
